// File: rtl/cd_rd_seq_pkg.sv
// Shared definitions for the packet-RAM read sequencer.
//   - Frame layout offsets: src, dst, len header bytes, then payload.
//   - FSM state encoding (2 bits).
//   - cd_max_len(): largest legal length byte for a given RAM word-address
//     width, so that the last byte index still fits in a byte address.
package cd_rd_seq_pkg;

    localparam int CD_OFS_SRC = 0;
    localparam int CD_OFS_DST = 1;
    localparam int CD_OFS_LEN = 2;
    localparam int CD_HDR_LEN = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } rd_state_t;

    // Buffer holds 2^(a_width+2) bytes; three of them are header.
    function automatic int unsigned cd_max_len(input int a_width);
        return (32'd1 << (a_width + 2)) - 32'(CD_HDR_LEN);
    endfunction

endpackage

// File: rtl/cd_rd_seq.sv
// cd_rd_seq: drains one committed frame at a time from the packet RAM and
// streams it byte by byte to the TX serializer.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   unread                RAM holds at least one committed, unread buffer
//   rd_byte               RAM read data, valid the cycle after rd_en
//   rd_addr, rd_en        RAM byte address / read strobe (combinational)
//   rd_done               one-cycle pulse releasing the current buffer
//   abort                 drop the frame in progress (ignored in IDLE)
//   out_data/valid/ready  byte stream to serializer, valid/ready handshake
//   out_last              final byte of frame, qualified by out_valid
//   len_err               one-cycle pulse: length byte exceeded capacity
//   busy                  sequencer is not idle
module cd_rd_seq
    import cd_rd_seq_pkg::*;
#(
    parameter int A_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 unread,
    input  logic [7:0]           rd_byte,
    output logic [A_WIDTH+1:0]   rd_addr,
    output logic                 rd_en,
    output logic                 rd_done,
    input  logic                 abort,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 len_err,
    output logic                 busy
);

    localparam int          BW      = A_WIDTH + 2;
    localparam int unsigned MAX_LEN = cd_max_len(A_WIDTH);

    rd_state_t       state_reg;
    logic [BW-1:0]   idx_reg;
    logic [BW-1:0]   len_reg;
    logic [7:0]      out_data_reg;
    logic            out_valid_reg;
    logic            out_last_reg;
    logic            rd_done_reg;
    logic            len_err_reg;

    // Index of the final byte (2+len), one bit wider so it cannot overflow.
    logic [BW:0]     last_idx;
    logic            is_len_byte;
    logic            len_over;
    logic            load_last;
    logic            handshake;

    assign last_idx    = {1'b0, len_reg} + (BW+1)'(CD_OFS_LEN);
    assign is_len_byte = (idx_reg == BW'(CD_OFS_LEN));
    assign len_over    = (32'(rd_byte) > MAX_LEN);

    // The length byte decides "last" from the fresh RAM data because len_reg
    // is only being loaded this cycle. Src/dst bytes can never be last.
    assign load_last = is_len_byte ? (rd_byte == 8'd0)
                     : ((idx_reg > BW'(CD_OFS_DST)) && ({1'b0, idx_reg} == last_idx));

    assign handshake = (state_reg == ST_SEND) && out_ready && !abort;

    // RAM read port is driven combinationally so data lands in LOAD.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = BW'(CD_OFS_SRC);
        case (state_reg)
            ST_IDLE: rd_en = unread;
            ST_SEND: begin
                if (handshake && !out_last_reg) begin
                    rd_en   = 1'b1;
                    rd_addr = idx_reg + BW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            len_reg       <= '0;
            out_data_reg  <= 8'd0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            rd_done_reg   <= 1'b0;
            len_err_reg   <= 1'b0;
        end else begin
            rd_done_reg <= 1'b0;
            len_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (unread) begin
                        idx_reg   <= BW'(CD_OFS_SRC);
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        rd_done_reg   <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        out_data_reg  <= rd_byte;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= load_last;
                        if (is_len_byte) begin
                            // Clamp so idx never has to count past the buffer end.
                            if (len_over) begin
                                len_reg     <= BW'(MAX_LEN);
                                len_err_reg <= 1'b1;
                            end else begin
                                len_reg <= BW'(rd_byte);
                            end
                        end
                        state_reg <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        rd_done_reg   <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (out_last_reg) begin
                            out_last_reg <= 1'b0;
                            rd_done_reg  <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            idx_reg   <= idx_reg + BW'(1);
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                // One cycle for the RAM to retire the buffer so IDLE sees a fresh unread.
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign rd_done   = rd_done_reg;
    assign len_err   = len_err_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cd_rd_seq.sv
// Bench for cd_rd_seq: behavioural packet RAM with a buffer ring, a
// scoreboard of expected {last, data} bytes, and a negedge monitor.
module tb_cd_rd_seq;

    logic        clk;
    logic        reset_n;
    logic        unread;
    logic [7:0]  rd_byte;
    logic [7:0]  rd_addr;
    logic        rd_en;
    logic        rd_done;
    logic        abort;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        len_err;
    logic        busy;

    cd_rd_seq #(.A_WIDTH(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .unread    (unread),
        .rd_byte   (rd_byte),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_done   (rd_done),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .len_err   (len_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- packet RAM model ----------------
    logic [7:0] ram [4][256];
    int committed = 0;
    int released  = 0;
    assign unread = (committed != released);

    always @(posedge clk) begin
        if (rd_en) rd_byte <= ram[released % 4][rd_addr];
        if (!reset_n)     released <= committed;
        else if (rd_done) released <= released + 1;
    end

    // ---------------- scoreboard / monitor ----------------
    logic [8:0] sb [$];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   frame_hs = 0, exp_addr = 0, n_done = 0, n_lenerr = 0, n_rden = 0, n_hs = 0;
    int   ev_cyc = 0, final_hs_cyc = 0, gap_b2b = 0;
    logic prev_hold = 0, prev_abort = 0, prev_last = 0;
    logic [7:0] prev_data = 0;
    logic [8:0] e;

    always @(negedge clk) begin
        if (!reset_n) begin
            frame_hs = 0; exp_addr = 0; prev_hold = 0; prev_abort = 0;
        end else begin
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(exp_addr));
                if (rd_addr == 8'd0) gap_b2b = cyc - final_hs_cyc;
                exp_addr++; n_rden++;
            end
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (prev_abort) begin
                check("abort_valid", 32'(out_valid), 32'd0);
                check("abort_done", 32'(rd_done), 32'd1);
            end
            if (out_valid && !out_ready) check("stall_rden", 32'(rd_en), 32'd0);
            if (rd_done) begin
                check("done_lat", 32'(cyc - ev_cyc), 32'd1);
                n_done++; frame_hs = 0; exp_addr = 0;
            end
            if (len_err) n_lenerr++;
            prev_hold  = out_valid && !out_ready && !abort;
            prev_abort = out_valid && abort;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && abort) begin
                ev_cyc = cyc;
            end else if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(out_data), 32'h1ff);
                end else begin
                    e = sb.pop_front();
                    check("data", 32'(out_data), 32'(e[7:0]));
                    check("last", 32'(out_last), 32'(e[8]));
                end
                $display("byte %0d: data=%02h last=%0d", frame_hs, out_data, out_last);
                frame_hs++; n_hs++;
                if (out_last) begin final_hs_cyc = cyc; ev_cyc = cyc; end
            end
        end
    end

    // ---------------- serializer-side driver ----------------
    int mode = 0;          // 0 ready, 1 stall byte 1 x10, 2 abort on byte 3, 3 stall forever
    int stall_cnt = 0;
    bit abort_fired = 0;

    initial begin
        out_ready = 1'b1;
        abort     = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            abort     = 1'b0;
            case (mode)
                1: if (out_valid && frame_hs == 1 && stall_cnt < 10) begin
                       out_ready = 1'b0; stall_cnt++;
                   end
                2: if (out_valid && frame_hs == 3 && !abort_fired) begin
                       abort = 1'b1; abort_fired = 1;
                   end
                3: if (frame_hs >= 1) out_ready = 1'b0;
                default: ;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic commit_frame(input logic [7:0] b[], input int n_exp);
        for (int i = 0; i < b.size(); i++) ram[committed % 4][i] = b[i];
        for (int i = 0; i < n_exp; i++) sb.push_back({(i == b.size() - 1), b[i]});
        committed++;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin @(negedge clk); k++; end
        check("done_cnt", 32'(n_done), 32'(target));
    endtask

    logic [7:0] fr[];
    int d0, l0, r0, h0;

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(out_data), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_done", 32'(rd_done), 0);
        check("rst_lenerr", 32'(len_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rden", 32'(rd_en), 0);
        check("rst_addr", 32'(rd_addr), 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Basic 5-byte frame
        d0 = n_done; l0 = n_lenerr; r0 = n_rden;
        fr = '{8'h01, 8'h02, 8'h02, 8'hAA, 8'hBB};
        commit_frame(fr, 5);
        wait_done(d0 + 1, 100);
        repeat (3) @(negedge clk);
        check("t1_done", 32'(n_done - d0), 1);
        check("t1_lenerr", 32'(n_lenerr - l0), 0);
        check("t1_rden", 32'(n_rden - r0), 5);
        check("t1_sb", 32'(sb.size()), 0);

        // len = 0
        d0 = n_done; h0 = n_hs;
        fr = '{8'h05, 8'h06, 8'h00};
        commit_frame(fr, 3);
        wait_done(d0 + 1, 100);
        repeat (3) @(negedge clk);
        check("t2_bytes", 32'(n_hs - h0), 3);
        check("t2_done", 32'(n_done - d0), 1);
        check("t2_sb", 32'(sb.size()), 0);

        // Backpressure on byte 1
        d0 = n_done; r0 = n_rden; stall_cnt = 0; mode = 1;
        fr = '{8'h10, 8'h20, 8'h01, 8'h30};
        commit_frame(fr, 4);
        wait_done(d0 + 1, 200);
        repeat (3) @(negedge clk);
        mode = 0;
        check("t3_stalls", 32'(stall_cnt), 10);
        check("t3_rden", 32'(n_rden - r0), 4);
        check("t3_sb", 32'(sb.size()), 0);

        // Oversized length byte: clamp to 253 -> 256 bytes total
        d0 = n_done; l0 = n_lenerr; h0 = n_hs;
        fr = new[256];
        for (int i = 0; i < 256; i++) fr[i] = 8'(i * 7 + 3);
        fr[2] = 8'hFF;
        commit_frame(fr, 256);
        wait_done(d0 + 1, 1000);
        repeat (3) @(negedge clk);
        check("t4_lenerr", 32'(n_lenerr - l0), 1);
        check("t4_bytes", 32'(n_hs - h0), 256);
        check("t4_sb", 32'(sb.size()), 0);

        // Two buffers back to back
        d0 = n_done; h0 = n_hs;
        fr = '{8'h41, 8'h42, 8'h01, 8'h43};
        commit_frame(fr, 4);
        fr = '{8'h51, 8'h52, 8'h02, 8'h53, 8'h54};
        commit_frame(fr, 5);
        wait_done(d0 + 2, 200);
        repeat (3) @(negedge clk);
        check("t5_gap", 32'(gap_b2b), 2);
        check("t5_bytes", 32'(n_hs - h0), 9);
        check("t5_sb", 32'(sb.size()), 0);

        // Abort with out_ready on byte 3
        d0 = n_done; abort_fired = 0; mode = 2;
        fr = '{8'h61, 8'h62, 8'h04, 8'h63, 8'h64, 8'h65, 8'h66};
        commit_frame(fr, 3);
        wait_done(d0 + 1, 200);
        @(negedge clk);
        check("t6_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        mode = 0;
        check("t6_aborted", 32'(abort_fired), 1);
        check("t6_done", 32'(n_done - d0), 1);
        check("t6_sb", 32'(sb.size()), 0);

        // Reset while stalled in SEND
        d0 = n_done; mode = 3;
        fr = '{8'h71, 8'h72, 8'h01, 8'h73};
        commit_frame(fr, 4);
        begin
            int k = 0;
            while (!(out_valid && frame_hs == 1) && k < 100) begin @(negedge clk); k++; end
            check("t7_reach", 32'(out_valid && frame_hs == 1), 1);
        end
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t7_valid", 32'(out_valid), 0);
        check("t7_data", 32'(out_data), 0);
        check("t7_busy", 32'(busy), 0);
        check("t7_rden", 32'(rd_en), 0);
        check("t7_done", 32'(rd_done), 0);
        sb.delete();
        mode = 0;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t7_idle", 32'(busy), 0);
        check("t7_nodone", 32'(n_done - d0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
